ysyx_23060180_mem_arbiter: RTL and testbench

- Shares the core's single memory port between two requesters: instruction fetch (IFU, port 0) and load/store unit (LSU, port 1).
- Sits between the multi-cycle CPU core and the memory model or bus.
- Arbitrates, registers the winning request, sequences one outstanding transaction to memory and returns the response to the owner.
- A timeout aborts the transaction with an error response, so a lost response cannot hang the core.

---
 rtl/ysyx_23060180_pkg.sv | 12 +
 rtl/ysyx_23060180_arb2.sv | 20 ++
 rtl/ysyx_23060180_mem_arbiter.sv | 119 +++++++++++
 tb/tb_ysyx_23060180_mem_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060180_pkg.sv
// ysyx_23060180_pkg: shared state encoding, port IDs and error data for the memory arbiter
package ysyx_23060180_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;
    localparam logic PORT_IFU = 1'b0;
    localparam logic PORT_LSU = 1'b1;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;
endpackage

// File: rtl/ysyx_23060180_arb2.sv
// ysyx_23060180_arb2: combinational 2-way arbiter (IFU=bit 0, LSU=bit 1)
//   req[1:0]  in   request vector
//   rr_last   in   last owner, loses a round-robin tie
//   lsu_prio  in   1 = LSU wins ties, 0 = round-robin
//   gnt[1:0]  out  one-hot grant (0 when nobody requests)
//   owner     out  winning port ID
module ysyx_23060180_arb2
    import ysyx_23060180_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_last,
    input  logic       lsu_prio,
    output logic [1:0] gnt,
    output logic       owner
);
    always_comb begin
        owner = &req ? (lsu_prio ? PORT_LSU : ~rr_last) : req[1];
        gnt   = {req[1] & owner, req[0] & ~owner};
    end
endmodule

// File: rtl/ysyx_23060180_mem_arbiter.sv
// ysyx_23060180_mem_arbiter: shares one memory port between IFU and LSU, one transaction in flight
//   clk, rstn_in                 clock, asynchronous active-low reset
//   ifu_* / lsu_*  (requester)   req/we/addr/wdata/wmask in; gnt/rvalid/rdata/err out
//   mem_*          (memory)      req/we/addr/wdata/wmask out; gnt/rvalid/rdata in
module ysyx_23060180_mem_arbiter
    import ysyx_23060180_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter bit          LSU_PRIO    = 1'b1,
    parameter logic [31:0] ERR_DATA    = ERR_DATA_DEF
) (
    input  logic        clk,
    input  logic        rstn_in,
    input  logic        ifu_req,
    input  logic        ifu_we,
    input  logic [31:0] ifu_addr,
    input  logic [31:0] ifu_wdata,
    input  logic [3:0]  ifu_wmask,
    output logic        ifu_gnt,
    output logic        ifu_rvalid,
    output logic [31:0] ifu_rdata,
    output logic        ifu_err,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_gnt,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    state_t      state, state_n;
    logic        owner, rr_last, err_q, arb_owner, grant, busy, done, tmo, abort;
    logic [1:0]  arb_gnt;
    logic [31:0] cnt, rdata_q;

    ysyx_23060180_arb2 u_arb (
        .req      ({lsu_req, ifu_req}),
        .rr_last  (rr_last),
        .lsu_prio (LSU_PRIO),
        .gnt      (arb_gnt),
        .owner    (arb_owner)
    );

    assign grant = (state == IDLE) && (|arb_gnt);
    assign busy  = (state == REQ) || (state == WAIT);
    assign done  = (state == REQ && mem_gnt) || (state == WAIT && mem_rvalid);
    // >= rather than == so a grant landing exactly on the last budget cycle
    // still leaves the following WAIT covered by the timeout
    assign tmo   = (TIMEOUT_CYC != 0) && (cnt >= TIMEOUT_CYC - 1);
    assign abort = busy && !done && tmo;

    assign ifu_gnt    = (state == IDLE) && arb_gnt[0];
    assign lsu_gnt    = (state == IDLE) && arb_gnt[1];
    assign ifu_rvalid = (state == RESP) && (owner == PORT_IFU);
    assign lsu_rvalid = (state == RESP) && (owner == PORT_LSU);
    assign ifu_rdata  = rdata_q;
    assign lsu_rdata  = rdata_q;
    assign ifu_err    = err_q;
    assign lsu_err    = err_q;
    assign mem_req    = (state == REQ);

    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = grant ? REQ : IDLE;
            REQ:     state_n = mem_gnt ? WAIT : (abort ? RESP : REQ);
            WAIT:    state_n = (mem_rvalid || abort) ? RESP : WAIT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            owner     <= PORT_IFU;
            rr_last   <= PORT_LSU;
            cnt       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (grant) begin
                owner     <= arb_owner;
                rr_last   <= arb_owner;
                cnt       <= '0;
                mem_we    <= arb_owner ? lsu_we    : ifu_we;
                mem_addr  <= arb_owner ? lsu_addr  : ifu_addr;
                mem_wdata <= arb_owner ? lsu_wdata : ifu_wdata;
                mem_wmask <= arb_owner ? lsu_wmask : ifu_wmask;
            end else if (busy) begin
                cnt <= cnt + 32'd1;
            end
            if (state == WAIT && mem_rvalid) begin
                rdata_q <= mem_we ? '0 : mem_rdata;
                err_q   <= 1'b0;
            end else if (abort) begin
                rdata_q <= ERR_DATA;
                err_q   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_23060180_mem_arbiter.sv
// tb_ysyx_23060180_mem_arbiter: two arbiter instances (A: LSU priority, 64-cycle timeout; B: round-robin, 8-cycle timeout)
module tb_ysyx_23060180_mem_arbiter;
    logic clk = 1'b0;
    logic rstn;
    logic [1:0]       ifu_req, ifu_we, lsu_req, lsu_we, mem_gnt, mem_rvalid;
    logic [1:0][31:0] ifu_addr, ifu_wdata, lsu_addr, lsu_wdata, mem_rdata;
    logic [1:0][3:0]  ifu_wmask, lsu_wmask;
    logic [1:0]       ifu_gnt, lsu_gnt, ifu_rvalid, lsu_rvalid, ifu_err, lsu_err, mem_req, mem_we;
    logic [1:0][31:0] ifu_rdata, lsu_rdata, mem_addr, mem_wdata;
    logic [1:0][3:0]  mem_wmask;
    int  tests = 0;
    int  fails = 0;
    bit  rr [2];

    always #5 clk = ~clk;

    ysyx_23060180_mem_arbiter #(.TIMEOUT_CYC(64), .LSU_PRIO(1'b1), .ERR_DATA(32'hDEADBEEF)) u_a (
        .clk(clk), .rstn_in(rstn),
        .ifu_req(ifu_req[0]), .ifu_we(ifu_we[0]), .ifu_addr(ifu_addr[0]), .ifu_wdata(ifu_wdata[0]),
        .ifu_wmask(ifu_wmask[0]), .ifu_gnt(ifu_gnt[0]), .ifu_rvalid(ifu_rvalid[0]),
        .ifu_rdata(ifu_rdata[0]), .ifu_err(ifu_err[0]),
        .lsu_req(lsu_req[0]), .lsu_we(lsu_we[0]), .lsu_addr(lsu_addr[0]), .lsu_wdata(lsu_wdata[0]),
        .lsu_wmask(lsu_wmask[0]), .lsu_gnt(lsu_gnt[0]), .lsu_rvalid(lsu_rvalid[0]),
        .lsu_rdata(lsu_rdata[0]), .lsu_err(lsu_err[0]),
        .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_wmask(mem_wmask[0]), .mem_gnt(mem_gnt[0]), .mem_rvalid(mem_rvalid[0]), .mem_rdata(mem_rdata[0])
    );

    ysyx_23060180_mem_arbiter #(.TIMEOUT_CYC(8), .LSU_PRIO(1'b0), .ERR_DATA(32'hDEADBEEF)) u_b (
        .clk(clk), .rstn_in(rstn),
        .ifu_req(ifu_req[1]), .ifu_we(ifu_we[1]), .ifu_addr(ifu_addr[1]), .ifu_wdata(ifu_wdata[1]),
        .ifu_wmask(ifu_wmask[1]), .ifu_gnt(ifu_gnt[1]), .ifu_rvalid(ifu_rvalid[1]),
        .ifu_rdata(ifu_rdata[1]), .ifu_err(ifu_err[1]),
        .lsu_req(lsu_req[1]), .lsu_we(lsu_we[1]), .lsu_addr(lsu_addr[1]), .lsu_wdata(lsu_wdata[1]),
        .lsu_wmask(lsu_wmask[1]), .lsu_gnt(lsu_gnt[1]), .lsu_rvalid(lsu_rvalid[1]),
        .lsu_rdata(lsu_rdata[1]), .lsu_err(lsu_err[1]),
        .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_wmask(mem_wmask[1]), .mem_gnt(mem_gnt[1]), .mem_rvalid(mem_rvalid[1]), .mem_rdata(mem_rdata[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_pl(input int d, input bit p, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] wm);
        if (p) begin
            lsu_we[d] = we; lsu_addr[d] = a; lsu_wdata[d] = wd; lsu_wmask[d] = wm;
        end else begin
            ifu_we[d] = we; ifu_addr[d] = a; ifu_wdata[d] = wd; ifu_wmask[d] = wm;
        end
    endtask

    task automatic rnd_pl(input int d, input bit p);
        set_pl(d, p, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
    endtask

    task automatic chk_quiet(input int d, input string tag);
        chk(tag, 32'({lsu_rvalid[d], ifu_rvalid[d]}), 32'd0);
    endtask

    // Entered and left at #1 after a rising edge with DUT d in IDLE.
    // stall = cycles before mem_gnt, lat = cycles from mem_gnt to mem_rvalid, drop = response lost.
    task automatic txn(input int d, input logic [1:0] reqs, input bit rnd, input int stall,
                       input int lat, input bit drop, input logic [31:0] rd);
        int t, k, gc, rc, ce;
        bit w, ab, we;
        logic [31:0] a, wd, er;
        logic [3:0] wm;
        if (reqs[0] && !ifu_req[d]) begin
            if (rnd) rnd_pl(d, 1'b0);
            ifu_req[d] = 1'b1;
        end
        if (reqs[1] && !lsu_req[d]) begin
            if (rnd) rnd_pl(d, 1'b1);
            lsu_req[d] = 1'b1;
        end
        w = (ifu_req[d] && lsu_req[d]) ? ((d == 0) ? 1'b1 : ~rr[d]) : lsu_req[d];
        rr[d] = w;
        we = w ? lsu_we[d] : ifu_we[d];
        a  = w ? lsu_addr[d] : ifu_addr[d];
        wd = w ? lsu_wdata[d] : ifu_wdata[d];
        wm = w ? lsu_wmask[d] : ifu_wmask[d];
        #1;
        chk("grant", 32'({lsu_gnt[d], ifu_gnt[d]}), w ? 32'd2 : 32'd1);
        t  = (d == 0) ? 64 : 8;
        gc = stall;
        rc = drop ? (1 << 20) : stall + lat;
        k  = t - 1;
        if (k == gc) k++;
        ab = k < rc;
        ce = ab ? k : rc;
        for (int c = 0; c <= ce; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                if (w) lsu_req[d] = 1'b0;
                else   ifu_req[d] = 1'b0;
            end
            chk("mem_req", 32'(mem_req[d]), 32'(c <= gc));
            chk("mem_addr", mem_addr[d], a);
            chk("mem_we", 32'(mem_we[d]), 32'(we));
            chk("mem_wdata", mem_wdata[d], wd);
            chk("mem_wmask", 32'(mem_wmask[d]), 32'(wm));
            chk_quiet(d, "rvalid_busy");
            chk("gnt_busy", 32'({lsu_gnt[d], ifu_gnt[d]}), 32'd0);
            mem_gnt[d]    = (c == gc);
            mem_rvalid[d] = (c == rc) || (c < gc && $urandom_range(0, 1) == 1);
            mem_rdata[d]  = (c == rc) ? rd : $urandom;
        end
        @(posedge clk); #1;
        mem_gnt[d]    = 1'b0;
        mem_rvalid[d] = 1'($urandom_range(0, 1));
        mem_rdata[d]  = $urandom;
        er = ab ? 32'hDEADBEEF : (we ? 32'd0 : rd);
        chk("rvalid", 32'({lsu_rvalid[d], ifu_rvalid[d]}), w ? 32'd2 : 32'd1);
        chk("rdata", w ? lsu_rdata[d] : ifu_rdata[d], er);
        chk("err", 32'(w ? lsu_err[d] : ifu_err[d]), 32'(ab));
        chk("mem_req_resp", 32'(mem_req[d]), 32'd0);
        @(posedge clk); #1;
        chk_quiet(d, "rvalid_after");
        mem_rvalid[d] = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input int d);
        while (ifu_req[d] || lsu_req[d]) txn(d, 2'b00, 1'b0, 0, 1, 1'b0, $urandom);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        ifu_req = '0; ifu_we = '0; lsu_req = '0; lsu_we = '0;
        mem_gnt = '0; mem_rvalid = '0; mem_rdata = '0;
        ifu_addr = '0; ifu_wdata = '0; lsu_addr = '0; lsu_wdata = '0;
        ifu_wmask = '0; lsu_wmask = '0;
        rr[0] = 1'b1; rr[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_mem_req", 32'(mem_req[d]), 32'd0);
            chk("rst_mem_we", 32'(mem_we[d]), 32'd0);
            chk("rst_mem_addr", mem_addr[d], 32'd0);
            chk("rst_mem_wdata", mem_wdata[d], 32'd0);
            chk("rst_mem_wmask", 32'(mem_wmask[d]), 32'd0);
            chk("rst_gnt", 32'({lsu_gnt[d], ifu_gnt[d]}), 32'd0);
            chk_quiet(d, "rst_rvalid");
            chk("rst_rdata", ifu_rdata[d] | lsu_rdata[d], 32'd0);
            chk("rst_err", 32'({lsu_err[d], ifu_err[d]}), 32'd0);
        end

        set_pl(0, 1'b0, 1'b0, 32'h8000_0000, 32'd0, 4'h0);
        txn(0, 2'b01, 1'b0, 0, 1, 1'b0, 32'h0010_0073);

        txn(0, 2'b11, 1'b1, 0, 1, 1'b0, $urandom);
        txn(0, 2'b00, 1'b0, 1, 2, 1'b0, $urandom);

        txn(1, 2'b11, 1'b1, 0, 1, 1'b0, $urandom);
        txn(1, 2'b11, 1'b1, 0, 1, 1'b0, $urandom);
        txn(1, 2'b11, 1'b1, 0, 1, 1'b0, $urandom);
        drain(1);

        set_pl(0, 1'b1, 1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF);
        txn(0, 2'b10, 1'b0, 0, 1, 1'b0, $urandom);

        txn(0, 2'b01, 1'b1, 10, 2, 1'b0, $urandom);

        txn(1, 2'b01, 1'b1, 0, 1, 1'b1, $urandom);
        for (int i = 0; i < 3; i++) begin
            mem_rvalid[1] = 1'b1;
            @(posedge clk); #1;
            chk_quiet(1, "stray_rvalid");
        end
        mem_rvalid[1] = 1'b0;
        txn(1, 2'b10, 1'b1, 3, 4, 1'b0, $urandom);
        txn(1, 2'b01, 1'b1, 3, 5, 1'b0, $urandom);
        txn(1, 2'b10, 1'b1, 9, 1, 1'b0, $urandom);

        for (int i = 0; i < 20; i++)
            txn(0, 2'($urandom_range(1, 3)), 1'b1, $urandom_range(0, 5), $urandom_range(1, 4), 1'b0, $urandom);
        drain(0);
        for (int i = 0; i < 20; i++)
            txn(1, 2'($urandom_range(1, 3)), 1'b1, $urandom_range(0, 5), $urandom_range(1, 4),
                $urandom_range(0, 7) == 0, $urandom);
        drain(1);

        rnd_pl(0, 1'b0);
        ifu_req[0] = 1'b1;
        #1 chk("rst_txn_gnt", 32'({lsu_gnt[0], ifu_gnt[0]}), 32'd1);
        @(posedge clk); #1;
        ifu_req[0] = 1'b0;
        mem_gnt[0] = 1'b1;
        mem_rvalid[0] = 1'b0;
        chk("rst_txn_req", 32'(mem_req[0]), 32'd1);
        @(posedge clk); #1;
        mem_gnt[0] = 1'b0;
        chk("rst_txn_wait", 32'(mem_req[0]), 32'd0);
        rstn = 1'b0;
        rr[0] = 1'b1; rr[1] = 1'b1;
        #1;
        chk("rst_mid_req", 32'(mem_req[0]), 32'd0);
        chk("rst_mid_addr", mem_addr[0], 32'd0);
        chk_quiet(0, "rst_mid_rvalid");
        mem_rvalid[0] = 1'b1;
        mem_rdata[0] = $urandom;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk_quiet(0, "rst_stray");
            chk("rst_stray_req", 32'(mem_req[0]), 32'd0);
        end
        mem_rvalid[0] = 1'b0;
        txn(0, 2'b01, 1'b1, 1, 1, 1'b0, $urandom);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
